booth_r4_seq_mult: RTL and testbench

BOOTH_R4_SEQ_MULT -- requirements
Module: booth_r4_seq_mult

---
 rtl/booth_pkg.sv | 17 +
 rtl/booth_r4_digit_enc.sv | 33 +++
 rtl/booth_r4_seq_mult.sv | 156 +++++++++++++++
 tb/tb_booth_r4_seq_mult.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier:
// controller state encoding and the per-operation digit count.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } booth_state_t;

    // Number of radix-4 digits retired per multiply. Operands are widened
    // by two bits, so WIDTH+2 bits of multiplier give WIDTH/2+1 digits.
    function automatic int digit_count(input int width);
        return (width / 2) + 1;
    endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth digit recoder: turns one multiplier triplet
// (b[2i+1], b[2i], b[2i-1]) into the partial-product select controls.
module booth_r4_digit_enc (
    input  logic [2:0] triplet,
    output logic       x,
    output logic       x_2,
    output logic       comp,
    output logic       not_comp
);

    // Decode the triplet: +-1*a, +-2*a, or zero (000 and 111).
    always_comb begin
        x        = 1'b0;
        x_2      = 1'b0;
        case (triplet)
            3'b001, 3'b010, 3'b101, 3'b110: begin
                x   = 1'b1;
                x_2 = 1'b0;
            end
            3'b011, 3'b100: begin
                x   = 1'b0;
                x_2 = 1'b1;
            end
            default: begin
                x   = 1'b0;
                x_2 = 1'b0;
            end
        endcase
        comp     = triplet[2];
        not_comp = ~triplet[2];
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier. Operands are widened to WIDTH+2
// bits (sign- or zero-extended) so one signed datapath serves both modes.
// One digit is retired per CALC cycle; the accumulator upper part is
// WIDTH+4 bits and the shifted-out low part collects the product LSBs.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int EXT_W = WIDTH + 2;
    localparam int ACC_W = WIDTH + 4;
    localparam int NDIG  = digit_count(WIDTH);
    localparam int CNT_W = $clog2(NDIG + 1);

    booth_state_t          state_r;
    booth_state_t          state_next_s;
    logic [EXT_W-1:0]      a_r;
    logic [EXT_W-1:0]      b_r;
    logic                  b_prev_r;
    logic [ACC_W-1:0]      hi_r;
    logic [EXT_W-1:0]      lo_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic [2*WIDTH-1:0]    product_r;

    logic                  accept_s;
    logic                  last_digit_s;
    logic                  a_sign_s;
    logic                  b_sign_s;
    logic [2:0]            triplet_s;
    logic                  x_s;
    logic                  x_2_s;
    logic                  comp_s;
    logic                  not_comp_s;
    logic [ACC_W-1:0]      a_wide_s;
    logic [ACC_W-1:0]      sel_s;
    logic [ACC_W-1:0]      pp_s;
    logic [ACC_W-1:0]      sum_s;

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

    booth_r4_digit_enc u_digit_enc (
        .triplet  (triplet_s),
        .x        (x_s),
        .x_2      (x_2_s),
        .comp     (comp_s),
        .not_comp (not_comp_s)
    );

    // Control decode: start acceptance, last-digit detect, next state.
    always_comb begin
        accept_s     = start && (state_r != ST_CALC);
        last_digit_s = (cnt_r == CNT_W'(NDIG - 1));
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_CALC;
                else       state_next_s = ST_IDLE;
            end
            ST_CALC: begin
                if (last_digit_s) state_next_s = ST_DONE;
                else              state_next_s = ST_CALC;
            end
            ST_DONE: begin
                if (start) state_next_s = ST_CALC;
                else       state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath: pick 0/a/2a, complement for negative digits, accumulate.
    always_comb begin
        a_sign_s  = is_signed & a[WIDTH-1];
        b_sign_s  = is_signed & b[WIDTH-1];
        triplet_s = {b_r[1], b_r[0], b_prev_r};
        a_wide_s  = {{2{a_r[EXT_W-1]}}, a_r};
        if (x_s) begin
            sel_s = a_wide_s;
        end else if (x_2_s) begin
            sel_s = {a_wide_s[ACC_W-2:0], 1'b0};
        end else begin
            sel_s = {ACC_W{1'b0}};
        end
        pp_s  = (sel_s & {ACC_W{not_comp_s}}) | (~sel_s & {ACC_W{comp_s}});
        sum_s = hi_r + pp_s + {{(ACC_W-1){1'b0}}, comp_s};
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture and per-digit accumulate / arithmetic shift by 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= {EXT_W{1'b0}};
            b_r      <= {EXT_W{1'b0}};
            b_prev_r <= 1'b0;
            hi_r     <= {ACC_W{1'b0}};
            lo_r     <= {EXT_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            a_r      <= {{2{a_sign_s}}, a};
            b_r      <= {{2{b_sign_s}}, b};
            b_prev_r <= 1'b0;
            hi_r     <= {ACC_W{1'b0}};
            lo_r     <= {EXT_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (state_r == ST_CALC) begin
            hi_r     <= {{2{sum_s[ACC_W-1]}}, sum_s[ACC_W-1:2]};
            lo_r     <= {sum_s[1:0], lo_r[EXT_W-1:2]};
            b_prev_r <= b_r[1];
            b_r      <= {2'b00, b_r[EXT_W-1:2]};
            cnt_r    <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r    <= cnt_r;
        end
    end

    // Registered outputs: busy tracks CALC, done/product follow DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            busy_r <= (state_next_s == ST_CALC);
            done_r <= (state_r == ST_DONE);
            if (state_r == ST_DONE) begin
                product_r <= {hi_r[WIDTH-3:0], lo_r};
            end else begin
                product_r <= product_r;
            end
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult: directed corners, control
// timing, random 16-bit operands and an exhaustive 4-bit sweep.
module tb_booth_r4_seq_mult;

    logic        clk = 1'b0;
    logic        rst;

    logic        start16, sgn16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;

    logic        start4, sgn4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  prod4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_r4_seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .is_signed(sgn16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .product(prod16)
    );

    booth_r4_seq_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .is_signed(sgn4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
    );

    function automatic logic [31:0] ref16(input logic s, input logic [15:0] x, input logic [15:0] y);
        longint ex, ey, p;
        ex = s ? longint'($signed(x)) : longint'(x);
        ey = s ? longint'($signed(y)) : longint'(y);
        p  = ex * ey;
        return p[31:0];
    endfunction

    function automatic logic [7:0] ref4(input logic s, input logic [3:0] x, input logic [3:0] y);
        int ex, ey, p;
        ex = s ? int'($signed(x)) : int'(x);
        ey = s ? int'($signed(y)) : int'(y);
        p  = ex * ey;
        return p[7:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle; returns #1 after the accepting edge.
    task automatic launch16(input logic s, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        start16 = 1'b1; sgn16 = s; a16 = x; b16 = y;
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    // Counts edges until done (bounded) and busy-high samples on the way.
    task automatic wait_done16(output int n, output int bc, output logic got);
        n = 0; bc = 0; got = 1'b0;
        while (!got && n < 40) begin
            if (busy16) bc++;
            @(posedge clk); #1;
            n++;
            if (done16) got = 1'b1;
        end
    endtask

    task automatic full_op16(input string tag, input logic s, input logic [15:0] x, input logic [15:0] y,
                             input logic chk_timing);
        int n, bc; logic got;
        launch16(s, x, y);
        wait_done16(n, bc, got);
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_product"}, 64'(prod16), 64'(ref16(s, x, y)));
        if (chk_timing) begin
            check({tag, "_latency"}, 64'(n), 64'd10);
            check({tag, "_busy_cycles"}, 64'(bc), 64'd9);
        end
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, 64'(done16), 64'd0);
    endtask

    initial begin
        int n, bc, cnt; logic got;
        logic [31:0] first;
        logic [15:0] rx, ry;
        logic        rs;

        rst = 1'b1; start16 = 1'b0; sgn16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
        start4 = 1'b0; sgn4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_busy", 64'(busy16), 64'd0);
        check("reset_done", 64'(done16), 64'd0);
        check("reset_product", 64'(prod16), 64'd0);

        // Corners, with full timing checks on the first one.
        full_op16("uns_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        check("uns_ffff_const", 64'(prod16), 64'hFFFE0001);
        full_op16("sgn_8000_8000", 1'b1, 16'h8000, 16'h8000, 1'b1);
        check("sgn_8000_const", 64'(prod16), 64'h40000000);
        full_op16("sgn_ffff_0001", 1'b1, 16'hFFFF, 16'h0001, 1'b0);
        check("sgn_ffff_const", 64'(prod16), 64'hFFFFFFFF);
        full_op16("sgn_7fff_8000", 1'b1, 16'h7FFF, 16'h8000, 1'b0);
        check("sgn_7fff_const", 64'(prod16), 64'hC0008000);
        full_op16("zero_a", 1'b1, 16'h0000, 16'h8001, 1'b0);
        full_op16("zero_b", 1'b0, 16'hBEEF, 16'h0000, 1'b0);

        // Start pulsed in the third CALC cycle must be ignored.
        launch16(1'b0, 16'h1234, 16'h0056);
        repeat (2) @(posedge clk);
        #1 start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; sgn16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        wait_done16(n, bc, got);
        check("ign_done_seen", 64'(got), 64'd1);
        check("ign_latency", 64'(n), 64'd7);
        check("ign_product", 64'(prod16), 64'(ref16(1'b0, 16'h1234, 16'h0056)));
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done16) cnt++;
        end
        check("ign_no_extra_done", 64'(cnt), 64'd0);

        // Reset in the fourth CALC cycle discards the operation.
        launch16(1'b0, 16'h00FF, 16'h0F0F);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst_mid_busy", 64'(busy16), 64'd0);
        check("rst_mid_done", 64'(done16), 64'd0);
        check("rst_mid_product", 64'(prod16), 64'd0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done16 || busy16) cnt++;
        end
        check("rst_mid_quiet", 64'(cnt), 64'd0);

        // Back-to-back: new start presented in the DONE cycle.
        first = ref16(1'b0, 16'h1234, 16'h0002);
        launch16(1'b0, 16'h1234, 16'h0002);
        repeat (9) @(posedge clk);
        #1;
        check("b2b_busy_low", 64'(busy16), 64'd0);
        start16 = 1'b1; sgn16 = 1'b0; a16 = 16'd3; b16 = 16'd5;
        @(posedge clk); #1 start16 = 1'b0;
        check("b2b_first_done", 64'(done16), 64'd1);
        check("b2b_first_product", 64'(prod16), 64'(first));
        check("b2b_busy_again", 64'(busy16), 64'd1);
        bc = 0; n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done16) got = 1'b1;
            else if (n < 10) check("b2b_product_held", 64'(prod16), 64'(first));
        end
        check("b2b_second_latency", 64'(n), 64'd10);
        check("b2b_second_product", 64'(prod16), 64'h0000000F);

        // Random operands in both modes.
        for (int i = 0; i < 40; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            full_op16("rand16", rs, rx, ry, 1'b0);
        end

        // Exhaustive 4-bit sweep, both modes.
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    @(negedge clk);
                    start4 = 1'b1; sgn4 = 1'(m); a4 = 4'(x); b4 = 4'(y);
                    @(posedge clk); #1 start4 = 1'b0;
                    n = 0; got = 1'b0;
                    while (!got && n < 20) begin
                        @(posedge clk); #1;
                        n++;
                        if (done4) got = 1'b1;
                    end
                    if (!got) check("w4_timeout", 64'(got), 64'd1);
                    check("w4_product", 64'(prod4), 64'(ref4(1'(m), 4'(x), 4'(y))));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
